fu_result_queue: RTL
====================

FU_RESULT_QUEUE -- requirements
Module: fu_result_queue

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries, power of two, at least 2.
REQ-002 Parameter TAG_W, default 6, reservation-station/ROB tag width.
REQ-003 Parameter DATA_W, default 32, result data width.
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 flush  in  1  synchronous mispredict flush; discards all entries.
REQ-007 fu_valid  in  1  FU presents a completed result this cycle.
REQ-008 fu_tag  in  TAG_W  destination tag of the FU result.
REQ-009 fu_data  in  DATA_W  FU result value.
REQ-010 fu_ready  out  1  queue accepts a result this cycle.
REQ-011 cdb_req  out  1  request to the CDB arbiter (one bit of its request vector).
REQ-012 cdb_grant  in  1  this FU's bit of the arbiter's registered fu_sel.
REQ-013 cdb_o  out  cdb_struct_t  broadcast payload {valid, tag, data}.
REQ-014 grant_err  out  1  sticky flag: grant received while the queue was empty.

Function
REQ-015 Circular FIFO; rd_ptr, wr_ptr and count wrap modulo DEPTH.
REQ-016 Push when fu_valid && fu_ready; entry written at the clock edge; visible at head no earlier than the next cycle (no bypass).
REQ-017 fu_ready = (count != DEPTH); a pop in the same cycle does not raise fu_ready.
REQ-018 fu_valid while full: no write, no state change; the FU holds its result.
REQ-019 Pop when cdb_grant && count != 0; cdb_o in the same cycle = {1, head tag, head data}.
REQ-020 cdb_o.valid = 0, tag = 0 and data = 0 in every cycle without a pop.
REQ-021 Arbiter grant lags its request by one cycle; cdb_req = (count >= 2) || (count == 1 && !cdb_grant), so the last entry is never double-requested.
REQ-022 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-023 Grant with count == 0: no pop, cdb_o.valid = 0, grant_err set until reset.
REQ-024 Flush: next-cycle count, rd_ptr and wr_ptr = 0; push and pop in the flush cycle are discarded; cdb_o.valid = 0 in the flush cycle.
REQ-025 Results leave in strict arrival order; every accepted result is broadcast exactly once unless flushed.
REQ-026 Latency: push at cycle N -> cdb_req at N+1 -> earliest broadcast at N+2.

Reset
REQ-027 rst_n low asynchronously clears pointers, count and grant_err; cdb_req = 0, cdb_o = 0, fu_ready = 1 while low.
REQ-028 Reset mid-operation drops all queued results; no broadcast occurs in the first cycle after deassertion.
REQ-029 Entry storage needs no reset; it is never read while count == 0.

Structure
REQ-030 cdb_struct_t is defined in the shared struct header and used by this block and the CDB arbiter; there is no local redefinition.
REQ-031 DEPTH, TAG_W and DATA_W defaults come from the shared constants header.
REQ-032 Single module, no sub-modules; storage is a register array indexed by the pointers.

Verification
REQ-033 Push tag 5/data 0xA at N, grant at N+2 -> cdb_req=1 at N+1, cdb_o={1,5,0xA} at N+2, cdb_req=0 at N+2.
REQ-034 Push 4 results without grants -> fu_ready=0 with count 4; 5th fu_valid is held; grant -> the 1st result is broadcast, fu_ready=1 the next cycle.
REQ-035 Count 2, push and grant in the same cycle -> count stays 2, order is preserved across pointer wrap after 6 such cycles.
REQ-036 Grant with an empty queue -> cdb_o.valid=0, grant_err=1 and stays 1.
REQ-037 Count 3, flush with simultaneous grant and push -> no broadcast; next cycle count 0, cdb_req 0.
REQ-038 rst_n low for one cycle with count 2 -> outputs clear immediately; no broadcast after release until new pushes arrive.

Source files
------------

// File: rtl/fu_result_queue_pkg.sv
// Shared CDB constants and broadcast payload type for the FU result queue and the CDB arbiter.
package fu_result_queue_pkg;

    localparam int unsigned FRQ_DEPTH  = 4;
    localparam int unsigned FRQ_TAG_W  = 6;
    localparam int unsigned FRQ_DATA_W = 32;

    typedef struct packed {
        logic                  valid;
        logic [FRQ_TAG_W-1:0]  tag;
        logic [FRQ_DATA_W-1:0] data;
    } cdb_struct_t;

endpackage

// File: rtl/fu_result_queue.sv
// Per-FU result FIFO: buffers completed results and broadcasts them on the CDB in arrival order.
module fu_result_queue
    import fu_result_queue_pkg::*;
#(
    parameter int unsigned DEPTH  = FRQ_DEPTH,
    parameter int unsigned TAG_W  = FRQ_TAG_W,
    parameter int unsigned DATA_W = FRQ_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              fu_valid,
    input  logic [TAG_W-1:0]  fu_tag,
    input  logic [DATA_W-1:0] fu_data,
    output logic              fu_ready,
    output logic              cdb_req,
    input  logic              cdb_grant,
    output cdb_struct_t       cdb_o,
    output logic              grant_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [TAG_W-1:0]  r_tag_mem  [DEPTH];
    logic [DATA_W-1:0] r_data_mem [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_grant_err;

    logic              w_empty;
    logic              w_push;
    logic              w_pop;

    assign w_empty   = (r_count == CNT_W'(0));
    assign fu_ready  = (r_count != CNT_W'(DEPTH));
    assign w_push    = fu_valid && fu_ready && !flush;
    assign w_pop     = cdb_grant && !w_empty && !flush;
    assign grant_err = r_grant_err;

    // The grant answers last cycle's request, so a lone entry being granted is not requested again.
    assign cdb_req = (r_count >= CNT_W'(2)) || ((r_count == CNT_W'(1)) && !cdb_grant);

    // Entry storage; only read when the queue holds data, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tag_mem[r_wr_ptr]  <= fu_tag;
            r_data_mem[r_wr_ptr] <= fu_data;
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the queue and discards same-cycle traffic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky record of a grant arriving with nothing to broadcast.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant_err <= 1'b0;
        end else if (cdb_grant && w_empty) begin
            r_grant_err <= 1'b1;
        end
    end

    // Broadcast the head in the grant cycle; the bus is all-zero otherwise.
    always_comb begin
        cdb_o = '0;
        if (w_pop) begin
            cdb_o.valid = 1'b1;
            cdb_o.tag   = FRQ_TAG_W'(r_tag_mem[r_rd_ptr]);
            cdb_o.data  = FRQ_DATA_W'(r_data_mem[r_rd_ptr]);
        end
    end

endmodule
